// File: rtl/i2s_tx_serializer.sv
// ============================================================================
// i2s_tx_serializer
// ----------------------------------------------------------------------------
// Transmit end of the codec serial audio link. Accepts parallel left/right
// samples and drives a standard I2S stream (bclk, lrclk, sdata) toward the
// DAC. The bit clock and frame clock are derived from the system clock.
//
// Double-buffered: one sample pair waits in a holding register while the
// previous pair is shifted out. At every frame start the holding pair, if
// present, moves into the shift registers. If the holding register is empty
// but a pair is offered in that exact cycle, the pair bypasses straight into
// the shift registers. Otherwise the previous pair is repeated and an
// underrun pulse is raised.
//
// Ports:
//   clk          system clock, the only clock
//   reset        asynchronous, active-high reset
//   l_data_in    left sample, two's complement, DATA_W bits
//   r_data_in    right sample, two's complement, DATA_W bits
//   load_valid   sample pair on l/r_data_in is valid
//   load_ready   holding register can accept a pair (registered)
//   bclk         I2S bit clock
//   lrclk        word select: 0 = left slot, 1 = right slot
//   sdata        serial data, MSB first, one bclk after the lrclk edge
//   frame_start  one-clk pulse when a new frame begins
//   underrun     one-clk pulse when a frame starts with no new sample
//
// Parameters:
//   DATA_W    sample width in bits, must be <= SLOT_W-1
//   SLOT_W    bclk periods per channel slot (frame = 2*SLOT_W bclk)
//   BCLK_DIV  clk cycles per bclk half-period (>= 1)
// ============================================================================
module i2s_tx_serializer #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] l_data_in,
    input  logic [DATA_W-1:0] r_data_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              frame_start,
    output logic              underrun
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] SLOT_SIZE = CNT_W'(SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);

    // ------------------------------------------------------------------
    // Serial bit lookup. Slot position s carries channel bit DATA_W-s for
    // s in 1..DATA_W; position 0 is the one-bclk I2S delay and positions
    // past the sample are zero padding.
    // ------------------------------------------------------------------
    function automatic logic slot_bit(input logic [DATA_W-1:0] word,
                                      input logic [CNT_W-1:0]  pos);
        logic result;
        result = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if ((int'(pos) >= 1) && (i == (DATA_W - int'(pos)))) begin
                result = word[i];
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  div_cnt_r;
    logic              bclk_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic              lrclk_r;
    logic              sdata_r;
    logic              frame_start_r;
    logic              underrun_r;
    logic              load_ready_r;
    logic              holding_full_r;
    logic [DATA_W-1:0] holding_l_r;
    logic [DATA_W-1:0] holding_r_r;
    logic [DATA_W-1:0] shift_l_r;
    logic [DATA_W-1:0] shift_r_r;

    // ------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------
    logic              div_wrap_s;
    logic              fall_s;
    logic [CNT_W-1:0]  bit_next_s;
    logic              frame_begin_s;
    logic              right_slot_s;
    logic [CNT_W-1:0]  slot_pos_s;
    logic [DATA_W-1:0] shift_l_next_s;
    logic [DATA_W-1:0] shift_r_next_s;
    logic              bypass_s;
    logic              starve_s;
    logic              accept_s;
    logic              holding_full_next_s;
    logic              sdata_next_s;

    // Divider wrap, falling-event detection and next bit position
    always_comb begin
        div_wrap_s = (div_cnt_r == DIV_LAST);
        // A toggle while bclk is high is the 1->0 falling event
        fall_s     = div_wrap_s && bclk_r;
        if (bit_cnt_r == BIT_LAST) begin
            bit_next_s = {CNT_W{1'b0}};
        end else begin
            bit_next_s = bit_cnt_r + CNT_W'(1);
        end
        frame_begin_s = fall_s && (bit_next_s == {CNT_W{1'b0}});
        right_slot_s  = (bit_next_s >= SLOT_SIZE);
        if (right_slot_s) begin
            slot_pos_s = bit_next_s - SLOT_SIZE;
        end else begin
            slot_pos_s = bit_next_s;
        end
    end

    // Frame-start reload selection: holding pair, bypass pair, or repeat
    always_comb begin
        shift_l_next_s = shift_l_r;
        shift_r_next_s = shift_r_r;
        bypass_s       = 1'b0;
        starve_s       = 1'b0;
        if (frame_begin_s) begin
            if (holding_full_r) begin
                shift_l_next_s = holding_l_r;
                shift_r_next_s = holding_r_r;
            end else if (load_valid) begin
                // Source is just in time: skip the holding register
                shift_l_next_s = l_data_in;
                shift_r_next_s = r_data_in;
                bypass_s       = 1'b1;
            end else begin
                starve_s = 1'b1;
            end
        end else begin
            shift_l_next_s = shift_l_r;
            shift_r_next_s = shift_r_r;
        end
    end

    // Load handshake and holding-register occupancy
    always_comb begin
        // A pair consumed by the bypass must not also land in holding
        accept_s = load_valid && load_ready_r && !bypass_s;
        if (frame_begin_s && holding_full_r) begin
            holding_full_next_s = 1'b0;
        end else if (accept_s) begin
            holding_full_next_s = 1'b1;
        end else begin
            holding_full_next_s = holding_full_r;
        end
    end

    // Serial data for the new bit position, from the pair about to be live
    always_comb begin
        if (right_slot_s) begin
            sdata_next_s = slot_bit(shift_r_next_s, slot_pos_s);
        end else begin
            sdata_next_s = slot_bit(shift_l_next_s, slot_pos_s);
        end
    end

    // Bit-clock divider: bclk toggles each time div_cnt wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= 1'b0;
        end else if (div_wrap_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= ~bclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
            bclk_r    <= bclk_r;
        end
    end

    // Frame position and serial outputs, updated only on falling events
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // bit_cnt starts at the last position so the first fall is b=0
            bit_cnt_r <= BIT_LAST;
            lrclk_r   <= 1'b1;
            sdata_r   <= 1'b0;
        end else if (fall_s) begin
            bit_cnt_r <= bit_next_s;
            lrclk_r   <= right_slot_s;
            sdata_r   <= sdata_next_s;
        end else begin
            bit_cnt_r <= bit_cnt_r;
            lrclk_r   <= lrclk_r;
            sdata_r   <= sdata_r;
        end
    end

    // One-clk status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else begin
            frame_start_r <= frame_begin_s;
            underrun_r    <= starve_s;
        end
    end

    // Shift registers hold the pair currently on the wire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_l_r <= {DATA_W{1'b0}};
            shift_r_r <= {DATA_W{1'b0}};
        end else begin
            shift_l_r <= shift_l_next_s;
            shift_r_r <= shift_r_next_s;
        end
    end

    // Holding register, occupancy flag and registered ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holding_l_r    <= {DATA_W{1'b0}};
            holding_r_r    <= {DATA_W{1'b0}};
            holding_full_r <= 1'b0;
            load_ready_r   <= 1'b1;
        end else begin
            if (accept_s) begin
                holding_l_r <= l_data_in;
                holding_r_r <= r_data_in;
            end else begin
                holding_l_r <= holding_l_r;
                holding_r_r <= holding_r_r;
            end
            holding_full_r <= holding_full_next_s;
            load_ready_r   <= !holding_full_next_s;
        end
    end

    assign bclk        = bclk_r;
    assign lrclk       = lrclk_r;
    assign sdata       = sdata_r;
    assign frame_start = frame_start_r;
    assign underrun    = underrun_r;
    assign load_ready  = load_ready_r;

endmodule
